multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the uPower datapath, successor to the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a memory ready handshake with a parametrised timeout. It also counts retired instructions. It sits between the instruction register and the datapath enables: register file, ALU, PC, IR and data memory.

---
 rtl/multicycle_control_unit.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB) with memory timeout and retire counter.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes lock the FSM in TRAP until reset).
module multicycle_control_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [9:0]       xox,
    input  logic [8:0]       xoxo,
    input  logic [1:0]       xods,
    input  logic             mem_ready,
    input  logic             cond_taken,
    output logic             IMemRead,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegRead,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             mem_err,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALU   = 3'd0,
        C_LOAD  = 3'd1,
        C_STORE = 3'd2,
        C_BRU   = 3'd3,
        C_BRC   = 3'd4,
        C_ILL   = 3'd5
    } cls_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    function automatic cls_t decode_class(input logic [5:0] op);
        cls_t c;
        case (op)
            6'd31, 6'd14, 6'd15, 6'd24, 6'd26, 6'd28: c = C_ALU;
            6'd58, 6'd32, 6'd34, 6'd40, 6'd42:        c = C_LOAD;
            6'd38, 6'd44, 6'd37, 6'd36, 6'd62:        c = C_STORE;
            6'd18:                                    c = C_BRU;
            6'd19:                                    c = C_BRC;
            default:                                  c = C_ILL;
        endcase
        return c;
    endfunction

    state_t        state_r, state_next_s;
    cls_t          cls_r, cls_dec_s;
    logic [TW-1:0] tcnt_r;
    logic [CNT_W-1:0] retired_r;
    logic          expire_s, retire_s, waiting_s;
    logic          unused_s;

    // Extended opcodes have no effect in this generation.
    assign unused_s  = ^{xox, xoxo, xods};
    assign cls_dec_s = decode_class(opcode);
    assign waiting_s = ((state_r == FETCH) || (state_r == MEM)) && !mem_ready;

    // Expiry: this waiting cycle is the TIMEOUT-th without mem_ready; ready in the same cycle wins.
    always_comb begin
        expire_s = 1'b0;
        if ((TIMEOUT != 0) && waiting_s && (tcnt_r == TLAST)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Next-state and datapath enables.
    always_comb begin
        state_next_s = state_r;
        retire_s     = 1'b0;
        IMemRead     = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegRead      = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Branch       = 1'b0;
        case (state_r)
            FETCH: begin
                IMemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    state_next_s = DECODE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                if ((cls_dec_s == C_BRU) || (cls_dec_s == C_ILL)) begin
                    RegRead = 1'b0;
                end else begin
                    RegRead = 1'b1;
                end
                if (cls_dec_s == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                    state_next_s = TRAP;
`else
                    state_next_s = FETCH;
                    retire_s     = 1'b1;
`endif
                end else begin
                    state_next_s = EXEC;
                end
            end
            EXEC: begin
                case (cls_r)
                    C_BRU: begin
                        Branch       = 1'b1;
                        PCWrite      = 1'b1;
                        state_next_s = FETCH;
                        retire_s     = 1'b1;
                    end
                    C_BRC: begin
                        Branch       = 1'b1;
                        PCWrite      = cond_taken;
                        state_next_s = FETCH;
                        retire_s     = 1'b1;
                    end
                    C_ALU:   state_next_s = WB;
                    C_LOAD:  state_next_s = MEM;
                    C_STORE: state_next_s = MEM;
                    default: state_next_s = FETCH;
                endcase
            end
            MEM: begin
                if (cls_r == C_LOAD) begin
                    MemRead = 1'b1;
                end else begin
                    MemWrite = 1'b1;
                end
                if (mem_ready) begin
                    if (cls_r == C_LOAD) begin
                        state_next_s = WB;
                    end else begin
                        state_next_s = FETCH;
                        retire_s     = 1'b1;
                    end
                end else if (expire_s) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = MEM;
                end
            end
            WB: begin
                RegWrite     = 1'b1;
                state_next_s = FETCH;
                retire_s     = 1'b1;
            end
            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_next_s = TRAP;
`else
                state_next_s = FETCH;
`endif
            end
            default: state_next_s = FETCH;
        endcase
    end

    // State, class, timeout counter and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= FETCH;
            cls_r     <= C_ILL;
            tcnt_r    <= '0;
            retired_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r == DECODE) begin
                cls_r <= cls_dec_s;
            end else begin
                cls_r <= cls_r;
            end
            if (waiting_s && !expire_s) begin
                tcnt_r <= tcnt_r + TW'(1);
            end else begin
                tcnt_r <= '0;
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    assign mem_err = expire_s;
    assign state   = state_r;
    assign retired = retired_r;
`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_r == TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit (TIMEOUT=4, CNT_W=4); honours ILLEGAL_TRAP_EN.
module tb_multicycle_control_unit;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opcode = 6'd0;
    logic [9:0]    xox = 10'h2a5;
    logic [8:0]    xoxo = 9'h15a;
    logic [1:0]    xods = 2'd3;
    logic          mem_ready = 1'b0;
    logic          cond_taken = 1'b0;
    logic          IMemRead, IRWrite, PCWrite, RegRead, RegWrite;
    logic          MemRead, MemWrite, Branch, mem_err, illegal;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic [7:0]    en_s;

    multicycle_control_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .xox(xox), .xoxo(xoxo), .xods(xods),
        .mem_ready(mem_ready), .cond_taken(cond_taken),
        .IMemRead(IMemRead), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegRead(RegRead),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .mem_err(mem_err), .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Enable vector order: IMemRead IRWrite PCWrite RegRead RegWrite MemRead MemWrite Branch
    assign en_s = {IMemRead, IRWrite, PCWrite, RegRead, RegWrite, MemRead, MemWrite, Branch};

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [7:0] en;
        logic       err;
        logic       ill;
        logic [3:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic [7:0] en,
                            input logic err, input logic ill, input logic [3:0] ret);
        exp_t e;
        e.tag = tag; e.st = st; e.en = en; e.err = err; e.ill = ill; e.ret = ret;
        sb_q.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got no expectation, required one");
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, "/state"},   32'(state),   32'(e.st));
            check_val({e.tag, "/en"},      32'(en_s),    32'(e.en));
            check_val({e.tag, "/mem_err"}, 32'(mem_err), 32'(e.err));
            check_val({e.tag, "/illegal"}, 32'(illegal), 32'(e.ill));
            check_val({e.tag, "/retired"}, 32'(retired), 32'(e.ret));
        end
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic rdy, input logic cond,
                        input logic [2:0] st, input logic [7:0] en, input logic err,
                        input logic ill, input logic [3:0] ret);
        opcode     = op;
        mem_ready  = rdy;
        cond_taken = cond;
        push_exp(tag, st, en, err, ill, ret);
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        push_exp("reset", 3'd0, 8'h80, 1'b0, 1'b0, 4'd0);
        compare_head();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU, zero-wait memory: F D E WB
        step("alu_f",  6'd31, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 4'd0);
        step("alu_d",  6'd31, 1'b1, 1'b0, 3'd1, 8'h10, 1'b0, 1'b0, 4'd0);
        step("alu_e",  6'd31, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 4'd0);
        step("alu_wb", 6'd31, 1'b1, 1'b0, 3'd4, 8'h08, 1'b0, 1'b0, 4'd0);

        // LOAD with three MEM wait cycles
        step("ld_f",  6'd58, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 4'd1);
        step("ld_d",  6'd58, 1'b1, 1'b0, 3'd1, 8'h10, 1'b0, 1'b0, 4'd1);
        step("ld_e",  6'd58, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 4'd1);
        step("ld_m0", 6'd58, 1'b0, 1'b0, 3'd3, 8'h04, 1'b0, 1'b0, 4'd1);
        step("ld_m1", 6'd58, 1'b0, 1'b0, 3'd3, 8'h04, 1'b0, 1'b0, 4'd1);
        step("ld_m2", 6'd58, 1'b0, 1'b0, 3'd3, 8'h04, 1'b0, 1'b0, 4'd1);
        step("ld_m3", 6'd58, 1'b1, 1'b0, 3'd3, 8'h04, 1'b0, 1'b0, 4'd1);
        step("ld_wb", 6'd58, 1'b1, 1'b0, 3'd4, 8'h08, 1'b0, 1'b0, 4'd1);

        // Conditional branch, not taken then taken
        step("brc0_f", 6'd19, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 4'd2);
        step("brc0_d", 6'd19, 1'b1, 1'b0, 3'd1, 8'h10, 1'b0, 1'b0, 4'd2);
        step("brc0_e", 6'd19, 1'b1, 1'b0, 3'd2, 8'h01, 1'b0, 1'b0, 4'd2);
        step("brc1_f", 6'd19, 1'b1, 1'b1, 3'd0, 8'hE0, 1'b0, 1'b0, 4'd3);
        step("brc1_d", 6'd19, 1'b1, 1'b1, 3'd1, 8'h10, 1'b0, 1'b0, 4'd3);
        step("brc1_e", 6'd19, 1'b1, 1'b1, 3'd2, 8'h21, 1'b0, 1'b0, 4'd3);

        // Fetch timeout: mem_err on the 4th waiting cycle, no retire, counter restarts
        step("to_f0", 6'd31, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0, 1'b0, 4'd4);
        step("to_f1", 6'd31, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0, 1'b0, 4'd4);
        step("to_f2", 6'd31, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0, 1'b0, 4'd4);
        step("to_f3", 6'd31, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0, 4'd4);
        step("to_f4", 6'd31, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0, 1'b0, 4'd4);

        // STORE aborted by asynchronous reset while in MEM
        step("st_f", 6'd38, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 4'd4);
        step("st_d", 6'd38, 1'b1, 1'b0, 3'd1, 8'h10, 1'b0, 1'b0, 4'd4);
        step("st_e", 6'd38, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 4'd4);
        mem_ready = 1'b0;
        push_exp("st_m", 3'd3, 8'h02, 1'b0, 1'b0, 4'd4);
        @(negedge clk);
        compare_head();
        #2;
        rst_n = 1'b0;
        push_exp("st_rst", 3'd0, 8'h80, 1'b0, 1'b0, 4'd0);
        #1;
        compare_head();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 16 unconditional branches: counter walks 0..15 and wraps to 0
        for (int i = 0; i < 16; i++) begin
            step("bru_f", 6'd18, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 4'(i));
            step("bru_d", 6'd18, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 4'(i));
            step("bru_e", 6'd18, 1'b1, 1'b0, 3'd2, 8'h21, 1'b0, 1'b0, 4'(i));
        end

        // Illegal opcode
        step("ill_f", 6'd0, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 4'd0);
        step("ill_d", 6'd0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 4'd0);
`ifdef ILLEGAL_TRAP_EN
        step("trap0", 6'd31, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b1, 4'd0);
        step("trap1", 6'd31, 1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 4'd0);
        step("trap2", 6'd18, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b1, 4'd0);
        rst_n = 1'b0;
        push_exp("trap_rst", 3'd0, 8'hE0, 1'b0, 1'b0, 4'd0);
        #1;
        compare_head();
        rst_n = 1'b1;
`else
        step("ill_nop", 6'd31, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b0, 1'b0, 4'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
